// File: rtl/uc_movimento_multi.sv
// rtl/uc_movimento_multi.sv - SCAN elevator motion controller with door dwell and travel timeout
module uc_movimento_multi #(
  parameter int N_ANDARES = 8,
  parameter int W_ANDAR   = 3,
  parameter int T_PORTA   = 50,
  parameter int T_LIMITE  = 1000
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 iniciar,
  input  logic                 emergencia,
  input  logic                 pedido_valido,
  input  logic [W_ANDAR-1:0]   pedido_andar,
  output logic                 pedido_pronto,
  output logic                 pedido_rejeit,
  input  logic                 sensor_andar,
  output logic                 motor_sobe,
  output logic                 motor_desce,
  output logic                 porta_aberta,
  output logic                 chegou,
  output logic [W_ANDAR-1:0]   andar_atual,
  output logic [N_ANDARES-1:0] pendentes,
  output logic                 erro,
  output logic [3:0]           db_estado
);

  localparam int W_MOV   = $clog2(T_LIMITE);
  localparam int W_PORTA = $clog2(T_PORTA + 1);
  localparam logic [W_MOV-1:0]   MOV_MAX    = W_MOV'(T_LIMITE - 1);
  localparam logic [W_PORTA-1:0] PORTA_MAX  = W_PORTA'(T_PORTA - 1);
  localparam logic [W_ANDAR-1:0] ANDAR_TOPO = W_ANDAR'(N_ANDARES - 1);

  typedef enum logic [3:0] {
    INICIAL    = 4'd0,
    INICIALIZA = 4'd1,
    OCIOSO     = 4'd2,
    DECIDE     = 4'd3,
    SUBINDO    = 4'd4,
    DESCENDO   = 4'd5,
    REGISTRA   = 4'd6,
    CHECA      = 4'd7,
    PORTA      = 4'd8,
    ERRO       = 4'd9
  } estado_t;

  estado_t               estado, estado_prox;
  logic                  dir_sobe;
  logic                  sensor_q;
  logic                  entrou;
  logic                  rejeit_q;
  logic [W_MOV-1:0]      cnt_mov;
  logic [W_PORTA-1:0]    cnt_porta;
  logic [W_ANDAR-1:0]    andar_q;
  logic [N_ANDARES-1:0]  pend_q;

  logic                  borda;
  logic                  aceito;
  logic                  em_faixa;
  logic                  reinicia_porta;
  logic                  parada_aqui;
  logic                  entra_porta;
  logic [N_ANDARES-1:0]  mask_atual;
  logic [N_ANDARES-1:0]  mask_pedido;
  logic [N_ANDARES-1:0]  mask_ate_atual;
  logic [N_ANDARES-1:0]  acima;
  logic [N_ANDARES-1:0]  abaixo;
  logic [N_ANDARES-1:0]  set_mask;
  logic [N_ANDARES-1:0]  clr_mask;

  // Request handshake, floor masks and the stops above/below the cab
  always_comb begin
    pedido_pronto = (estado == OCIOSO)  || (estado == DECIDE)   ||
                    (estado == SUBINDO) || (estado == DESCENDO) ||
                    (estado == REGISTRA) || (estado == CHECA)   ||
                    (estado == PORTA);
    aceito         = pedido_valido && pedido_pronto;
    // A shift past the top bit yields zero, so an out-of-range floor has an empty mask
    mask_pedido    = N_ANDARES'(1) << pedido_andar;
    em_faixa       = |mask_pedido;
    mask_atual     = N_ANDARES'(1) << andar_q;
    mask_ate_atual = (mask_atual << 1) - N_ANDARES'(1);
    acima          = pend_q & ~mask_ate_atual;
    abaixo         = pend_q & (mask_atual - N_ANDARES'(1));
    parada_aqui    = |(pend_q & mask_atual);
    borda          = sensor_andar && !sensor_q;
    reinicia_porta = (estado == PORTA) && aceito && em_faixa && (mask_pedido == mask_atual);
  end

  // Next-state logic; emergency overrides every other transition
  always_comb begin
    estado_prox = estado;
    case (estado)
      INICIAL:    if (iniciar) estado_prox = INICIALIZA;
      INICIALIZA: estado_prox = OCIOSO;
      OCIOSO:     if (|pend_q) estado_prox = DECIDE;
      DECIDE: begin
        if (parada_aqui)
          estado_prox = PORTA;
        else if (dir_sobe ? |acima : |abaixo)
          estado_prox = dir_sobe ? SUBINDO : DESCENDO;
        else if (dir_sobe ? |abaixo : |acima)
          estado_prox = dir_sobe ? DESCENDO : SUBINDO;
        else
          estado_prox = OCIOSO;
      end
      SUBINDO: begin
        if (borda)
          estado_prox = (andar_q == ANDAR_TOPO) ? ERRO : REGISTRA;
        else if (cnt_mov == MOV_MAX)
          estado_prox = ERRO;
      end
      DESCENDO: begin
        if (borda)
          estado_prox = (andar_q == '0) ? ERRO : REGISTRA;
        else if (cnt_mov == MOV_MAX)
          estado_prox = ERRO;
      end
      REGISTRA:   estado_prox = CHECA;
      CHECA:      estado_prox = parada_aqui ? PORTA : (dir_sobe ? SUBINDO : DESCENDO);
      PORTA:      if (!reinicia_porta && (cnt_porta == PORTA_MAX)) estado_prox = DECIDE;
      ERRO:       if (iniciar) estado_prox = INICIALIZA;
      default:    estado_prox = INICIAL;
    endcase
    if (emergencia && (estado != INICIAL) && (estado != ERRO))
      estado_prox = ERRO;
  end

  // Pending-stop updates: new requests set bits, arriving at a floor clears its bit
  always_comb begin
    entra_porta = (estado_prox == PORTA) && (estado != PORTA);
    set_mask    = (aceito && em_faixa && !reinicia_porta) ? mask_pedido : '0;
    clr_mask    = entra_porta ? mask_atual : '0;
  end

  // State register, floor tracking, timers and the stop bitmap
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado    <= INICIAL;
      dir_sobe  <= 1'b1;
      sensor_q  <= 1'b0;
      entrou    <= 1'b0;
      rejeit_q  <= 1'b0;
      cnt_mov   <= '0;
      cnt_porta <= '0;
      andar_q   <= '0;
      pend_q    <= '0;
    end else begin
      estado   <= estado_prox;
      sensor_q <= sensor_andar;
      entrou   <= entra_porta;
      rejeit_q <= aceito && !em_faixa;

      if (estado == INICIALIZA || estado_prox == SUBINDO)
        dir_sobe <= 1'b1;
      else if (estado_prox == DESCENDO)
        dir_sobe <= 1'b0;

      // Movement timer restarts whenever the cab resumes motion
      if (estado == SUBINDO || estado == DESCENDO)
        cnt_mov <= cnt_mov + 1'b1;
      else
        cnt_mov <= '0;

      // A repeated request for the open floor holds the door longer
      if (estado == PORTA && !reinicia_porta)
        cnt_porta <= cnt_porta + 1'b1;
      else
        cnt_porta <= '0;

      if (estado == INICIALIZA)
        andar_q <= '0;
      else if (estado == REGISTRA)
        andar_q <= dir_sobe ? andar_q + 1'b1 : andar_q - 1'b1;

      if (estado == INICIALIZA)
        pend_q <= '0;
      else
        pend_q <= (pend_q | set_mask) & ~clr_mask;
    end
  end

  // Moore outputs decoded from the state so reset clears them immediately
  always_comb begin
    motor_sobe    = (estado == SUBINDO) ||
                    (((estado == REGISTRA) || (estado == CHECA)) && dir_sobe);
    motor_desce   = (estado == DESCENDO) ||
                    (((estado == REGISTRA) || (estado == CHECA)) && !dir_sobe);
    porta_aberta  = (estado == PORTA);
    chegou        = (estado == PORTA) && entrou;
    erro          = (estado == ERRO);
    pedido_rejeit = rejeit_q;
    andar_atual   = andar_q;
    pendentes     = pend_q;
    db_estado     = estado;
  end

endmodule

// File: tb/tb_uc_movimento_multi.sv
// tb/tb_uc_movimento_multi.sv - directed self-checking bench for uc_movimento_multi
module tb_uc_movimento_multi;

  localparam int N  = 8;
  localparam int WA = 4;

  logic          clock;
  logic          reset;
  logic          iniciar;
  logic          emergencia;
  logic          pedido_valido;
  logic [WA-1:0] pedido_andar;
  logic          pedido_pronto;
  logic          pedido_rejeit;
  logic          sensor_andar;
  logic          motor_sobe;
  logic          motor_desce;
  logic          porta_aberta;
  logic          chegou;
  logic [WA-1:0] andar_atual;
  logic [N-1:0]  pendentes;
  logic          erro;
  logic [3:0]    db_estado;

  int checks = 0;
  int errors = 0;

  uc_movimento_multi #(
    .N_ANDARES(N), .W_ANDAR(WA), .T_PORTA(50), .T_LIMITE(1000)
  ) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .emergencia(emergencia),
    .pedido_valido(pedido_valido), .pedido_andar(pedido_andar),
    .pedido_pronto(pedido_pronto), .pedido_rejeit(pedido_rejeit),
    .sensor_andar(sensor_andar), .motor_sobe(motor_sobe), .motor_desce(motor_desce),
    .porta_aberta(porta_aberta), .chegou(chegou), .andar_atual(andar_atual),
    .pendentes(pendentes), .erro(erro), .db_estado(db_estado)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic pede(input int andar);
    pedido_valido = 1'b1;
    pedido_andar  = WA'(andar);
    tick();
    pedido_valido = 1'b0;
  endtask

  // One floor of travel: sensor edge, REGISTRA, CHECA, then the decision out of CHECA
  task automatic andar_um;
    sensor_andar = 1'b1;
    tick();
    sensor_andar = 1'b0;
    tick();
    tick();
  endtask

  task automatic espera_porta(output int n, output int n_cheg);
    n = 0;
    n_cheg = 0;
    while (porta_aberta && n < 500) begin
      n++;
      if (chegou) n_cheg++;
      tick();
    end
  endtask

  task automatic reinicia;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    tick();
  endtask

  // Motor interlock holds on every cycle outside reset
  always @(negedge clock)
    if (!reset)
      chk("interlock", 32'((motor_sobe & motor_desce) | (porta_aberta & (motor_sobe | motor_desce))), 0);

  initial begin
    int n, nc, c;
    reset = 1'b1; iniciar = 1'b0; emergencia = 1'b0;
    pedido_valido = 1'b0; pedido_andar = '0; sensor_andar = 1'b0;
    #12;
    chk("rst_estado", 32'(db_estado), 0);
    chk("rst_saidas", 32'({motor_sobe, motor_desce, porta_aberta, chegou, erro, pedido_pronto, pedido_rejeit}), 0);
    chk("rst_andar", 32'(andar_atual), 0);
    chk("rst_pend", 32'(pendentes), 0);
    reset = 1'b0;

    // Single trip 0 -> 3
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    chk("t1_inicializa", 32'(db_estado), 1);
    tick();
    chk("t1_ocioso", 32'(db_estado), 2);
    chk("t1_pronto", 32'(pedido_pronto), 1);
    pede(3);
    chk("t1_pend", 32'(pendentes), 8);
    tick();
    chk("t1_decide", 32'(db_estado), 3);
    chk("t1_motor_off", 32'(motor_sobe), 0);
    tick();
    chk("t1_subindo", 32'(db_estado), 4);
    chk("t1_motor_on", 32'(motor_sobe), 1);
    sensor_andar = 1'b1;
    tick();
    sensor_andar = 1'b0;
    chk("t1_registra", 32'({db_estado, motor_sobe}), (6 << 1) | 1);
    tick();
    chk("t1_checa", 32'({db_estado, motor_sobe}), (7 << 1) | 1);
    chk("t1_andar1", 32'(andar_atual), 1);
    tick();
    andar_um();
    andar_um();
    chk("t1_porta", 32'(db_estado), 8);
    chk("t1_andar3", 32'(andar_atual), 3);
    chk("t1_pend_limpo", 32'(pendentes), 0);
    chk("t1_motores", 32'({motor_sobe, motor_desce}), 0);
    espera_porta(n, nc);
    chk("t1_dwell", 32'(n), 50);
    chk("t1_chegou", 32'(nc), 1);
    tick();
    chk("t1_fim_ocioso", 32'(db_estado), 2);

    // SCAN: heading up to 5, request 0 at floor 2
    reinicia();
    chk("t2_andar0", 32'(andar_atual), 0);
    pede(5);
    tick();
    tick();
    andar_um();
    andar_um();
    chk("t2_andar2", 32'({andar_atual, db_estado}), (2 << 4) | 4);
    pede(0);
    chk("t2_pend", 32'(pendentes), 33);
    andar_um();
    andar_um();
    andar_um();
    chk("t2_porta5", 32'({andar_atual, db_estado}), (5 << 4) | 8);
    chk("t2_pend0", 32'(pendentes), 1);
    espera_porta(n, nc);
    tick();
    chk("t2_descendo", 32'({db_estado, motor_desce}), (5 << 1) | 1);
    for (int i = 0; i < 5; i++) andar_um();
    chk("t2_porta0", 32'({andar_atual, db_estado}), (0 << 4) | 8);
    chk("t2_pend_vazio", 32'(pendentes), 0);
    espera_porta(n, nc);
    tick();

    // Request for the current floor, then repeat during dwell
    pede(0);
    chk("t3_pend", 32'(pendentes), 1);
    tick();
    chk("t3_decide", 32'({db_estado, motor_sobe, motor_desce}), 3 << 2);
    tick();
    chk("t3_porta", 32'({db_estado, motor_sobe, motor_desce, chegou}), (8 << 3) | 1);
    chk("t3_pend_limpo", 32'(pendentes), 0);
    repeat (10) tick();
    pede(0);
    chk("t3_repete_pend", 32'(pendentes), 0);
    chk("t3_repete_porta", 32'(db_estado), 8);
    espera_porta(n, nc);
    chk("t3_dwell_reinicia", 32'(n), 50);
    chk("t3_sem_chegou", 32'(nc), 0);
    tick();

    // Out-of-range request
    pede(9);
    chk("t4_rejeit", 32'(pedido_rejeit), 1);
    chk("t4_pend", 32'(pendentes), 0);
    tick();
    chk("t4_rejeit_pulso", 32'(pedido_rejeit), 0);
    chk("t4_ocioso", 32'(db_estado), 2);

    // Travel timeout after reaching floor 1
    pede(2);
    tick();
    tick();
    andar_um();
    c = 0;
    while (db_estado == 4'd4 && c < 2000) begin
      c++;
      tick();
    end
    chk("t5_ciclos", 32'(c), 1000);
    chk("t5_erro", 32'({erro, db_estado, motor_sobe, motor_desce}), (1 << 6) | (9 << 2));
    chk("t5_andar", 32'(andar_atual), 1);
    chk("t5_pend_mantido", 32'(pendentes), 4);
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    chk("t5_inicializa", 32'(db_estado), 1);
    tick();
    chk("t5_andar0", 32'({andar_atual, pendentes}), 0);

    // Emergency while descending
    pede(1);
    tick();
    tick();
    andar_um();
    chk("t6_porta1", 32'({andar_atual, db_estado}), (1 << 4) | 8);
    espera_porta(n, nc);
    tick();
    pede(0);
    tick();
    tick();
    chk("t6_descendo", 32'(db_estado), 5);
    emergencia = 1'b1;
    tick();
    emergencia = 1'b0;
    chk("t6_erro", 32'({db_estado, motor_desce, erro}), (9 << 2) | 1);
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    tick();

    // Asynchronous reset during door dwell
    pede(0);
    tick();
    tick();
    chk("t7_porta", 32'(db_estado), 8);
    repeat (3) tick();
    #2 reset = 1'b1;
    #1;
    chk("t7_rst_estado", 32'(db_estado), 0);
    chk("t7_rst_saidas", 32'({porta_aberta, pedido_pronto, erro, chegou, motor_sobe, motor_desce}), 0);
    chk("t7_rst_pend", 32'({andar_atual, pendentes}), 0);
    tick();
    reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
